// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One shift-add or restoring-divide step per clock, with a start/busy/done handshake.
module muldiv_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FAST_SPECIAL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] mcand;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   shreg;      // multiplier during mul, dividend/quotient during div
  logic [XLEN-1:0]   divisor;
  logic [XLEN-1:0]   rem;
  logic              neg_res;
  logic              special;
  logic [XLEN-1:0]   special_val;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special_c, neg_c;
  logic [XLEN-1:0]   special_val_c;

  // Operand decode at accept time: magnitudes, result sign, special cases
  always_comb begin
    a_neg    = rs1_val[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU) |
                                  (op == OP_DIV)  | (op == OP_REM));
    b_neg    = rs2_val[XLEN-1] & ((op == OP_MULH) | (op == OP_DIV) | (op == OP_REM));
    a_mag    = a_neg ? (XLEN'(0) - rs1_val) : rs1_val;
    b_mag    = b_neg ? (XLEN'(0) - rs2_val) : rs2_val;
    div_zero = op[2] & (rs2_val == '0);
    div_ovf  = ((op == OP_DIV) | (op == OP_REM)) &
               (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_val == '1);
    special_c = div_zero | div_ovf;
    // Remainder follows the dividend; quotient and product follow the sign XOR
    neg_c    = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
    special_val_c = '0;
    if (div_zero)
      special_val_c = op[1] ? rs1_val : '1;
    else if (div_ovf)
      special_val_c = op[1] ? '0 : rs1_val;
  end

  logic [XLEN:0]     rem_sh;
  logic              sub_ok;
  logic [XLEN-1:0]   rem_sub;
  logic [2*XLEN-1:0] prod_step;

  // Per-step datapath
  always_comb begin
    rem_sh    = {rem, shreg[XLEN-1]};
    sub_ok    = rem_sh >= {1'b0, divisor};
    rem_sub   = rem_sh[XLEN-1:0] - divisor;
    prod_step = shreg[0] ? (prod + mcand) : prod;
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_val;

  // Sign fixup and result select for the FINISH state
  always_comb begin
    prod_fix = neg_res ? ((2*XLEN)'(0) - prod) : prod;
    quo_fix  = neg_res ? (XLEN'(0) - shreg) : shreg;
    rem_fix  = neg_res ? (XLEN'(0) - rem) : rem;
    fin_val  = '0;
    if (special)
      fin_val = special_val;
    else if (op_q == OP_MUL)
      fin_val = prod_fix[XLEN-1:0];
    else if (!op_q[2])
      fin_val = prod_fix[2*XLEN-1:XLEN];
    else if (!op_q[1])
      fin_val = quo_fix;
    else
      fin_val = rem_fix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      op_q        <= '0;
      cnt         <= '0;
      mcand       <= '0;
      prod        <= '0;
      shreg       <= '0;
      divisor     <= '0;
      rem         <= '0;
      neg_res     <= 1'b0;
      special     <= 1'b0;
      special_val <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q        <= op;
            neg_res     <= neg_c;
            special     <= special_c;
            special_val <= special_val_c;
            cnt         <= '0;
            busy        <= 1'b1;
            prod        <= '0;
            rem         <= '0;
            if (op[2]) begin
              shreg   <= a_mag;
              divisor <= b_mag;
              mcand   <= '0;
            end else begin
              shreg   <= b_mag;
              divisor <= '0;
              mcand   <= {{XLEN{1'b0}}, a_mag};
            end
            state <= ((FAST_SPECIAL != 0) && special_c) ? FINISH : RUN;
          end
        end
        RUN: begin
          if (op_q[2]) begin
            rem   <= sub_ok ? rem_sub : rem_sh[XLEN-1:0];
            shreg <= {shreg[XLEN-2:0], sub_ok};
          end else begin
            prod  <= prod_step;
            mcand <= {mcand[2*XLEN-2:0], 1'b0};
            shreg <= {1'b0, shreg[XLEN-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1))
            state <= FINISH;
        end
        FINISH: begin
          result <= fin_val;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at accept and
// compared (value and latency) when done pulses.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] exp;
    logic [31:0] acc;
    logic [31:0] lat;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  n_done   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sbv = longint'($signed(b));
    longint      ua = longint'({32'b0, a});
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = 64'(ua * ub);  return p[31:0];  end
      3'd1: begin p = 64'(sa * sbv); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub);  return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sbv);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sbv);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
    logic sp;
    sp = o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return sp ? 1 : 33;
  endfunction

  // Monitor: pop and compare on every done pulse
  always @(posedge clk) begin
    sb_t e;
    cyc = cyc + 1;
    #1;
    if (done) begin
      n_done++;
      if (sb.size() == 0)
        check("spurious_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("result", result, e.exp);
        check("latency", 32'(cyc) - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_override, input bit use_override);
    sb_t e;
    @(negedge clk);
    start = 1'b1; op = o; rs1_val = a; rs2_val = b;
    @(posedge clk);
    #1;
    e.exp = use_override ? exp_override : model(o, a, b);
    e.acc = 32'(cyc);
    e.lat = 32'(latency(o, a, b));
    sb.push_back(e);
    start = 1'b0;
    rs1_val = $urandom;
    rs2_val = $urandom;
    op = 3'($urandom_range(0, 7));
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++)
      @(posedge clk);
    #2;
    check("drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // mul, then mulh issued in the done cycle
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #2;
      if (done) break;
    end
    check("b2b_done_seen", {31'b0, done}, 32'd1);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    drain(60);

    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); drain(60);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1); drain(60);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);         drain(60);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);         drain(60);
    issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);                      drain(60);
    issue(3'd7, 32'd100, 32'd7, 32'd2, 1'b1);                       drain(60);

    // Special cases complete one cycle after accept
    issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);                 drain(10);
    issue(3'd6, 32'd5, 32'd0, 32'd5, 1'b1);                         drain(10);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1); drain(10);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);         drain(10);

    // Start while busy is ignored
    d0 = n_done;
    issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("busy_held", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs1_val = 32'd3; rs2_val = 32'd5;
    @(negedge clk);
    start = 1'b0;
    drain(60);
    repeat (40) @(posedge clk);
    check("one_done", 32'(n_done - d0), 32'd1);

    // Random operations against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      issue(3'(i % 8), a, b, 32'd0, 1'b0);
      drain(60);
    end

    // Reset mid-run discards the operation
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF1, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    sb.delete();
    d0 = n_done;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    check("no_done_after_rst", 32'(n_done - d0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide responder for the core's EXECUTE stage. Replaces fixed cycle-count stalling with an explicit start/busy/done handshake.
- The execute logic issues one M-extension operation with operands. It holds its stall while busy is high and captures the result on done.
- One shift-add or restoring-divide step per clock; no wide combinational multiplier or divider.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.
FAST_SPECIAL, 1, when 1 divide-by-zero and signed overflow complete in 1 cycle instead of XLEN+1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request strobe; accepted only on a rising edge where busy=0
op  input  3  funct3 encoding: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
rs1_val  input  XLEN  operand A (multiplicand/dividend)
rs2_val  input  XLEN  operand B (multiplier/divisor)
busy  output  1  operation in progress; start ignored while high
done  output  1  single-cycle pulse; result valid in the same cycle
result  output  XLEN  last completed result; held until the next done

Behaviour:
- Reset (async, any time, including mid-operation): busy=0, done=0, result=0, FSM=IDLE. Any in-flight operation is discarded with no done.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - On an edge where start=1, latch op and operands, set busy=1, clear iteration counter, go to RUN.
  - When a special case applies and FAST_SPECIAL=1, go directly to FINISH.
- RUN:
  - One step per edge. Counter counts 0..XLEN-1.
  - After step XLEN-1, go to FINISH.
- FINISH (one edge):
  - Apply sign fixup, write result, done=1, busy=0, return to IDLE.
- Latency:
  - Start sampled at edge T0; done=1 in the cycle after edge T0+XLEN+1.
  - Special cases with FAST_SPECIAL=1: done after edge T0+1.
- done is high for exactly one cycle; otherwise 0.
- start is ignored while busy=1: no queueing, latched operands unchanged.
- Back-to-back: start may be asserted in the done cycle. busy=0 then, so it is accepted on that edge.
- Operand changes after the accept edge have no effect.
- Multiply:
  - Convert operands to unsigned magnitudes. rs1 is signed for mulh/mulhsu; rs2 is signed for mulh only; mul treats both as unsigned (low half is identical).
  - 2*XLEN-bit shift-add accumulation over XLEN steps.
  - In FINISH, negate the 2*XLEN product when the operand signs differ.
  - mul returns product[XLEN-1:0]; mulh/mulhsu/mulhu return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes (signed ops only use magnitudes). Each step shifts one dividend bit into the remainder, trial-subtracts the divisor, and sets a quotient bit if non-negative.
  - Quotient is negated when the signs differ (div). Remainder takes the dividend's sign (rem).
  - Division by zero (any FAST_SPECIAL): div/divu return all ones; rem/remu return rs1_val.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): div returns 0x80000000; rem returns 0.
  - With FAST_SPECIAL=0, the special cases run the full XLEN steps but still yield the values above.
- result is updated only in FINISH; it is never partially visible.

Test Plan:
- Reset mid-run: start mul, assert rst at step 10 -> busy=0, done=0, result=0 immediately; no later done.
- mul 7 * 0xFFFFFFFD -> result 0xFFFFFFEB, done 33 cycles after accept. Then start mulh 0x80000000 * 0x80000000 in the done cycle -> accepted, result 0x40000000.
- mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; mulhu same operands -> 0xFFFFFFFE.
- div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; rem same operands -> 0xFFFFFFFF; divu 100 / 7 -> 14; remu 100 % 7 -> 2.
- divu 5 / 0 -> 0xFFFFFFFF; rem 5 / 0 -> 5. div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem -> 0. With FAST_SPECIAL=1, each completes 1 cycle after accept.
- Start pulsed while busy, with different operands -> ignored; original result returned; exactly one done pulse.
